// File: rtl/tl_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tl_ctrl_fsm -- main control FSM of the transaction-layer FIFO/arbiter path.
//
// Generates the one-hot-ish 4-bit state bus for the arbiter and FIFOs.
// Owns the programmable almost-full/almost-empty thresholds.
// Tracks idle/active/error status from the FIFO empty and overflow flags.
//
// Ports
//   clk            in   system clock, everything on posedge
//   reset          in   synchronous active-high reset
//   init           in   request to enter / stay in configuration (INIT)
//   umbral_alto_in in   proposed almost-full threshold  [UMBRAL_W]
//   umbral_bajo_in in   proposed almost-empty threshold [UMBRAL_W]
//   empties        in   per-FIFO empty flags, 1 = empty [NUM_FIFOS]
//   error_full     in   per-FIFO overflow pulses        [NUM_FIFOS]
//   state          out  registered FSM state
//   umbral_alto    out  active almost-full threshold
//   umbral_bajo    out  active almost-empty threshold
//   idle/active/error out  registered state decodes
//   error_src      out  sticky per-FIFO overflow record
// ---------------------------------------------------------------------------

// Per-FIFO sticky overflow flag. Sets on flag while enabled and holds
// until reset.
module tl_err_bit (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic flag_i,
  output logic sticky_o
);
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (reset)              sticky_q <= 1'b0;
    else if (en_i && flag_i) sticky_q <= 1'b1;
  end

  assign sticky_o = sticky_q;
endmodule

module tl_ctrl_fsm #(
  parameter int                    UMBRAL_W        = 4,
  parameter int                    NUM_FIFOS       = 8,
  parameter int                    IDLE_CYC        = 3,
  parameter logic [UMBRAL_W-1:0]   UMBRAL_ALTO_RST = 4'd12,
  parameter logic [UMBRAL_W-1:0]   UMBRAL_BAJO_RST = 4'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  umbral_alto_in,
  input  logic [UMBRAL_W-1:0]  umbral_bajo_in,
  input  logic [NUM_FIFOS-1:0] empties,
  input  logic [NUM_FIFOS-1:0] error_full,
  output logic [3:0]           state,
  output logic [UMBRAL_W-1:0]  umbral_alto,
  output logic [UMBRAL_W-1:0]  umbral_bajo,
  output logic                 idle,
  output logic                 active,
  output logic                 error,
  output logic [NUM_FIFOS-1:0] error_src
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);

  typedef enum logic [3:0] {
    S_RESET  = 4'b0000,
    S_INIT   = 4'b0001,
    S_IDLE   = 4'b0010,
    S_ACTIVE = 4'b0100,
    S_ERROR  = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [UMBRAL_W-1:0] alto_q, alto_d, bajo_q, bajo_d;
  logic                idle_q, idle_d, active_q, active_d, error_q, error_d;

  logic all_empty, any_err, cfg_ok;
  assign all_empty = &empties;
  assign any_err   = |error_full;
  // Equal thresholds are rejected, as is an inverted pair.
  assign cfg_ok    = umbral_bajo_in < umbral_alto_in;

  // -------------------------------------------------------------------------
  // State / output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      alto_q   <= UMBRAL_ALTO_RST;
      bajo_q   <= UMBRAL_BAJO_RST;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      idle_q   <= idle_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: error detect > init > normal transitions.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT: begin
        if (any_err)   state_d = S_ERROR;
        else if (init) state_d = S_INIT;
        else           state_d = S_IDLE;
      end
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
        else                 state_d = S_IDLE;
      end
      S_ACTIVE: begin
        if (any_err)   state_d = S_ERROR;
        else if (init) state_d = S_INIT;
        // The current all-empty cycle is the IDLE_CYC-th in a row.
        else if (all_empty && (cnt_q == CNT_W'(IDLE_CYC - 1))) state_d = S_IDLE;
        else           state_d = S_ACTIVE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values, registered alongside the state.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d    = '0;
    alto_d   = alto_q;
    bajo_d   = bajo_q;
    idle_d   = (state_d == S_IDLE);
    active_d = (state_d == S_ACTIVE);
    error_d  = (state_d == S_ERROR);

    // Counter only runs while remaining in ACTIVE; any exit or fresh entry
    // leaves it at zero.
    if (state_q == S_ACTIVE && state_d == S_ACTIVE && all_empty)
      cnt_d = (cnt_q == CNT_W'(IDLE_CYC)) ? cnt_q : cnt_q + CNT_W'(1);

    if (state_q == S_INIT && cfg_ok) begin
      alto_d = umbral_alto_in;
      bajo_d = umbral_bajo_in;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overflow record, one cell per FIFO. Accumulates in every
  // non-reset state, ERROR included.
  // -------------------------------------------------------------------------
  logic err_en;
  assign err_en = (state_q != S_RESET);

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_err
    tl_err_bit u_err (
      .clk      (clk),
      .reset    (reset),
      .en_i     (err_en),
      .flag_i   (error_full[g]),
      .sticky_o (error_src[g])
    );
  end

  assign state       = state_q;
  assign umbral_alto = alto_q;
  assign umbral_bajo = bajo_q;
  assign idle        = idle_q;
  assign active      = active_q;
  assign error       = error_q;

endmodule

// File: tb/tb_tl_ctrl_fsm.sv
module tb_tl_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] alto_in, bajo_in;
  logic [7:0] empties, error_full;
  logic [3:0] state, u_alto, u_bajo;
  logic       idle, active, error;
  logic [7:0] error_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_ctrl_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_alto_in (alto_in),
    .umbral_bajo_in (bajo_in),
    .empties        (empties),
    .error_full     (error_full),
    .state          (state),
    .umbral_alto    (u_alto),
    .umbral_bajo    (u_bajo),
    .idle           (idle),
    .active         (active),
    .error          (error),
    .error_src      (error_src)
  );

  typedef struct {
    logic       rst;
    logic       ini;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [7:0] emp;
    logic [7:0] ef;
    logic [3:0] e_state;
    logic [3:0] e_alto;
    logic [3:0] e_bajo;
    logic [7:0] e_src;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ini, logic [3:0] a, logic [3:0] b,
                              logic [7:0] emp, logic [7:0] ef, logic [3:0] st,
                              logic [3:0] ea, logic [3:0] eb, logic [7:0] src);
    vec_t v;
    v.rst = rst; v.ini = ini; v.a_in = a; v.b_in = b; v.emp = emp; v.ef = ef;
    v.e_state = st; v.e_alto = ea; v.e_bajo = eb; v.e_src = src;
    return v;
  endfunction

  // Apply inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic ini, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] emp, input logic [7:0] ef);
    @(negedge clk);
    reset = rst; init = ini; alto_in = a; bajo_in = b; empties = emp; error_full = ef;
    @(posedge clk);
    #1;
  endtask

  // Flags are decoded from the expected state independently of the DUT.
  task automatic chk(input string name, input logic [3:0] st, input logic [3:0] ea,
                     input logic [3:0] eb, input logic [7:0] src);
    logic ei, ea_f, ee;
    ei   = (st == 4'b0010);
    ea_f = (st == 4'b0100);
    ee   = (st == 4'b1000);
    checks++;
    if (state !== st || u_alto !== ea || u_bajo !== eb || idle !== ei ||
        active !== ea_f || error !== ee || error_src !== src) begin
      errors++;
      $display("FAIL %s: got st=%b alto=%0d bajo=%0d i/a/e=%b%b%b src=%h ; want st=%b alto=%0d bajo=%0d i/a/e=%b%b%b src=%h",
               name, state, u_alto, u_bajo, idle, active, error, error_src,
               st, ea, eb, ei, ea_f, ee, src);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; init = 1'b0; alto_in = '0; bajo_in = '0;
    empties = 8'hFF; error_full = 8'h00;

    //             rst ini alto bajo emp    ef     state    alto bajo src
    // reset and bring-up
    tbl.push_back(mk(1, 0, 0,  0,  8'hFF, 8'h00, 4'b0000, 12, 2, 8'h00));
    tbl.push_back(mk(1, 0, 0,  0,  8'hFF, 8'h00, 4'b0000, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0001, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0010, 12, 2, 8'h00));
    // configuration: IDLE->INIT does not load; loads once in INIT; 5/5 rejected
    tbl.push_back(mk(0, 1, 10, 3,  8'hFF, 8'h00, 4'b0001, 12, 2, 8'h00));
    tbl.push_back(mk(0, 1, 10, 3,  8'hFF, 8'h00, 4'b0001, 10, 3, 8'h00));
    tbl.push_back(mk(0, 1, 5,  5,  8'hFF, 8'h00, 4'b0001, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 5,  5,  8'hFF, 8'h00, 4'b0010, 10, 3, 8'h00));
    // activity and idle timing
    tbl.push_back(mk(0, 0, 0,  0,  8'hFE, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFB, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0010, 10, 3, 8'h00));
    // overflow, accumulation in ERROR, init ignored
    tbl.push_back(mk(0, 0, 0,  0,  8'hFE, 8'h00, 4'b0100, 10, 3, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFE, 8'h04, 4'b1000, 10, 3, 8'h04));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFE, 8'h00, 4'b1000, 10, 3, 8'h04));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFE, 8'h10, 4'b1000, 10, 3, 8'h14));
    tbl.push_back(mk(0, 1, 9,  1,  8'hFF, 8'h00, 4'b1000, 10, 3, 8'h14));
    // reset from ERROR
    tbl.push_back(mk(1, 0, 0,  0,  8'hFF, 8'h00, 4'b0000, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0001, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0010, 12, 2, 8'h00));
    // simultaneous: error beats init beats activity
    tbl.push_back(mk(0, 1, 0,  0,  8'h00, 8'h01, 4'b1000, 12, 2, 8'h01));
    tbl.push_back(mk(1, 0, 0,  0,  8'hFF, 8'h00, 4'b0000, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0001, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 0,  0,  8'hFF, 8'h00, 4'b0010, 12, 2, 8'h00));
    tbl.push_back(mk(0, 1, 0,  0,  8'h00, 8'h00, 4'b0001, 12, 2, 8'h00));
    // threshold boundaries: inverted pair held, extreme valid pair loaded on exit
    tbl.push_back(mk(0, 1, 3,  9,  8'hFF, 8'h00, 4'b0001, 12, 2, 8'h00));
    tbl.push_back(mk(0, 0, 15, 0,  8'hFF, 8'h00, 4'b0010, 15, 0, 8'h00));
    tbl.push_back(mk(0, 0, 7,  1,  8'hFF, 8'h00, 4'b0010, 15, 0, 8'h00));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ini, tbl[i].a_in, tbl[i].b_in, tbl[i].emp, tbl[i].ef);
      chk($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_alto, tbl[i].e_bajo, tbl[i].e_src);
    end

    // Hand sequence: from IDLE, enter ACTIVE, then count all-empty edges
    // until IDLE; exactly 3 are required.
    step(0, 0, 0, 0, 8'h7F, 8'h00);
    chk("seq_enter_active", 4'b0100, 15, 0, 8'h00);
    n = 0;
    do begin
      step(0, 0, 0, 0, 8'hFF, 8'h00);
      n++;
    end while (idle !== 1'b1 && n < 10);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL seq_idle_cycles: got %0d all-empty edges, want 3", n);
    end
    chk("seq_back_idle", 4'b0010, 15, 0, 8'h00);

    // Hand sequence: overflow while configuring beats init=1.
    step(0, 1, 0, 0, 8'hFF, 8'h00);
    chk("seq_to_init", 4'b0001, 15, 0, 8'h00);
    step(0, 1, 8, 4, 8'hFF, 8'h80);
    chk("seq_init_err", 4'b1000, 8, 4, 8'h80);
    step(0, 0, 0, 0, 8'hFF, 8'h00);
    chk("seq_err_sticky", 4'b1000, 8, 4, 8'h80);
    step(1, 1, 0, 0, 8'h00, 8'h01);
    chk("seq_reset_prio", 4'b0000, 12, 2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ctrl_fsm.md
Name: tl_ctrl_fsm

Overview:
Main control state machine for the transaction-layer FIFO/arbiter datapath. It generates the 4-bit `state` bus consumed by the arbiter and FIFOs. It owns the programmable almost-full/almost-empty thresholds driven to the FIFOs. It tracks global idle/active/error status from the FIFO empty and overflow flags.

Parameters:
UMBRAL_W, 4, width of threshold fields (matches FIFO depth pointer width)
NUM_FIFOS, 8, number of FIFOs monitored (4 input + 4 output)
IDLE_CYC, 3, consecutive all-empty cycles required to leave ACTIVE
UMBRAL_ALTO_RST, 4'd12, almost-full threshold after reset
UMBRAL_BAJO_RST, 4'd2, almost-empty threshold after reset

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
init  input  1  request to enter/stay in configuration state
umbral_alto_in  input  UMBRAL_W  proposed almost-full threshold
umbral_bajo_in  input  UMBRAL_W  proposed almost-empty threshold
empties  input  NUM_FIFOS  per-FIFO empty flags (1 = empty)
error_full  input  NUM_FIFOS  per-FIFO overflow pulses (push while full)
state  output  4  current FSM state, registered
umbral_alto  output  UMBRAL_W  active almost-full threshold to FIFOs
umbral_bajo  output  UMBRAL_W  active almost-empty threshold to FIFOs
idle  output  1  high while state == IDLE
active  output  1  high while state == ACTIVE
error  output  1  high while state == ERROR
error_src  output  NUM_FIFOS  sticky record of FIFOs that overflowed

Behaviour:
- Clock `clk` and synchronous active-high `reset` are decided. Reset is sampled only on posedge `clk`. No asynchronous paths.
- State encodings: RESET=4'b0000, INIT=4'b0001, IDLE=4'b0010, ACTIVE=4'b0100, ERROR=4'b1000. All outputs are registered. `idle`/`active`/`error` update in the same cycle as `state`.
- Reset values:
  - state=RESET
  - umbral_alto=UMBRAL_ALTO_RST, umbral_bajo=UMBRAL_BAJO_RST
  - idle=active=error=0
  - error_src=0
  - internal idle counter=0
- Reset asserted mid-operation, including in ERROR, returns to the full reset values at the next edge. Reset has priority over everything else.
- Transition priority per edge: reset > error detect > init > normal transitions.
- Error detect:
  - In INIT, IDLE or ACTIVE, if |error_full == 1, next state = ERROR.
  - error_src <= error_src | error_full in every non-reset state, including ERROR.
  - ERROR is sticky and exits only via reset. init is ignored in ERROR.
- RESET: leaves unconditionally to INIT one cycle after reset deasserts.
- INIT:
  - Each cycle with umbral_bajo_in < umbral_alto_in, both thresholds are loaded.
  - Otherwise the previous thresholds are held. Equal values are invalid.
  - init=0 leads to IDLE. init=1 stays in INIT.
  - Thresholds change only in INIT.
- IDLE:
  - init=1 leads to INIT.
  - Otherwise, if any empties bit is 0, go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE:
  - init=1 leads to INIT.
  - Counter increments (saturating at IDLE_CYC) each cycle empties is all ones. It clears to 0 on any empties bit of 0.
  - When empties is all ones and counter == IDLE_CYC-1, go to IDLE and clear the counter. So exactly IDLE_CYC consecutive all-empty cycles are required.
  - The counter clears on every entry to ACTIVE.
- Latency: an input sampled at edge n is reflected in `state` and the outputs after edge n (one cycle).

Test Plan:
- Reset and bring-up: hold reset 2 cycles, then deassert with init=0 -> state 0000 during reset; 0001 at first edge after; 0010 next edge. Thresholds stay 12/2 and idle=1.
- Configuration: init=1 with alto_in=10, bajo_in=3 -> umbral_alto=10, umbral_bajo=3. Then alto_in=5, bajo_in=5 -> thresholds unchanged at 10/3. Drop init -> IDLE.
- Activity and idle timing: from IDLE set empties=8'hFE -> ACTIVE next edge, active=1. Set empties=8'hFF for 2 cycles, then 8'hFB for 1 cycle, then 8'hFF for 3 cycles -> return to IDLE exactly at the 3rd all-empty edge.
- Overflow: in ACTIVE, pulse error_full=8'h04 for one cycle, then 8'h10 later -> state 1000 next edge, error=1, error_src=8'h14. Asserting init while in ERROR has no effect.
- Simultaneous events: in IDLE apply init=1, empties=8'h00 and error_full=8'h01 in the same cycle -> ERROR. Repeat without error_full -> INIT, not ACTIVE.
- Reset mid-operation: from ERROR with error_src=8'h14, assert reset 1 cycle -> state=0000, error_src=0, thresholds 12/2, error=0.
